// File: rtl/change_dispenser.sv
// Completion back end: captures a finished transaction, pulses the item vend,
// then pays change greedily in 20/10/5 coins over a req/ack handshake.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       done,
  input  logic       end_trans,
  input  logic [7:0] sum_money,
  input  logic [7:0] price,
  input  logic [1:0] item_select,
  input  logic       coin_ack,
  output logic       deno_20,
  output logic       deno_10,
  output logic       deno_5,
  output logic       vend_valid,
  output logic [1:0] vend_item,
  output logic       busy,
  output logic       change_done,
  output logic [7:0] remaining,
  output logic [2:0] residual,
  output logic [1:0] err_code
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNDERPAY = 2'd1;
  localparam logic [1:0] ERR_RESIDUAL = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_VEND, S_COIN, S_WAIT_ACK, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      price_q, price_d;
  logic [1:0]      item_q, item_d;
  logic [7:0]      rem_q, rem_d;
  logic [2:0]      coin_q, coin_d;   // {20, 10, 5} one-hot request
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            vend_valid_q, vend_valid_d;
  logic [1:0]      vend_item_q, vend_item_d;
  logic            busy_q, busy_d;
  logic            change_done_q, change_done_d;
  logic [2:0]      residual_q, residual_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      coin_val;

  always_comb begin
    coin_val = 8'd0;
    if (coin_q[2])      coin_val = 8'd20;
    else if (coin_q[1]) coin_val = 8'd10;
    else if (coin_q[0]) coin_val = 8'd5;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      sum_q         <= 8'd0;
      price_q       <= 8'd0;
      item_q        <= 2'd0;
      rem_q         <= 8'd0;
      coin_q        <= 3'd0;
      cnt_q         <= '0;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= 2'd0;
      busy_q        <= 1'b0;
      change_done_q <= 1'b0;
      residual_q    <= 3'd0;
      err_q         <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      price_q       <= price_d;
      item_q        <= item_d;
      rem_q         <= rem_d;
      coin_q        <= coin_d;
      cnt_q         <= cnt_d;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      busy_q        <= busy_d;
      change_done_q <= change_done_d;
      residual_q    <= residual_d;
      err_q         <= err_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    price_d       = price_q;
    item_d        = item_q;
    rem_d         = rem_q;
    coin_d        = coin_q;
    cnt_d         = cnt_q;
    vend_valid_d  = 1'b0;
    vend_item_d   = 2'd0;
    change_done_d = 1'b0;
    residual_d    = residual_q;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        if (done && end_trans) begin
          sum_d      = sum_money;
          price_d    = price;
          item_d     = item_select;
          err_d      = ERR_NONE;
          residual_d = 3'd0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (price_q == 8'd0) begin
          rem_d   = sum_q;
          state_d = S_COIN;
        end else if (price_q > sum_q) begin
          rem_d   = sum_q;
          err_d   = ERR_UNDERPAY;
          state_d = S_COIN;
        end else begin
          rem_d        = sum_q - price_q;
          vend_valid_d = 1'b1;
          vend_item_d  = item_q;
          state_d      = S_VEND;
        end
      end
      S_VEND: state_d = S_COIN;
      S_COIN: begin
        cnt_d = '0;
        if (rem_q >= 8'd20) begin
          coin_d  = 3'b100;
          state_d = S_WAIT_ACK;
        end else if (rem_q >= 8'd10) begin
          coin_d  = 3'b010;
          state_d = S_WAIT_ACK;
        end else if (rem_q >= 8'd5) begin
          coin_d  = 3'b001;
          state_d = S_WAIT_ACK;
        end else begin
          change_done_d = 1'b1;
          residual_d    = rem_q[2:0];
          if (err_q == ERR_NONE && rem_q[2:0] != 3'd0) err_d = ERR_RESIDUAL;
          state_d = S_FINISH;
        end
      end
      S_WAIT_ACK: begin
        // An ack on the expiry edge still pays the coin
        if (coin_ack) begin
          rem_d   = rem_q - coin_val;
          coin_d  = 3'd0;
          state_d = S_COIN;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          coin_d        = 3'd0;
          err_d         = ERR_TIMEOUT;
          change_done_d = 1'b1;
          state_d       = S_FINISH;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign deno_20     = coin_q[2];
  assign deno_10     = coin_q[1];
  assign deno_5      = coin_q[0];
  assign vend_valid  = vend_valid_q;
  assign vend_item   = vend_item_q;
  assign busy        = busy_q;
  assign change_done = change_done_q;
  assign remaining   = rem_q;
  assign residual    = residual_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       done, end_trans, coin_ack;
  logic [7:0] sum_money, price;
  logic [1:0] item_select;
  logic       deno_20, deno_10, deno_5, vend_valid, busy, change_done;
  logic [1:0] vend_item, err_code;
  logic [7:0] remaining;
  logic [2:0] residual;

  int checks = 0;
  int failures = 0;
  int hi;

  change_dispenser #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .done(done), .end_trans(end_trans),
    .sum_money(sum_money), .price(price), .item_select(item_select),
    .coin_ack(coin_ack), .deno_20(deno_20), .deno_10(deno_10), .deno_5(deno_5),
    .vend_valid(vend_valid), .vend_item(vend_item), .busy(busy),
    .change_done(change_done), .remaining(remaining), .residual(residual),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  wire [2:0]  deno = {deno_20, deno_10, deno_5};
  wire [20:0] all_out = {deno, vend_valid, vend_item, busy, change_done,
                         remaining, residual, err_code};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] s, input logic [7:0] p, input logic [1:0] it);
    done = 1'b1; end_trans = 1'b1; sum_money = s; price = p; item_select = it;
    step();
    done = 1'b0; end_trans = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; done = 1'b0; end_trans = 1'b0; coin_ack = 1'b0;
    sum_money = 8'd0; price = 8'd0; item_select = 2'd0;
    #12;
    chk("reset_outputs", 32'(all_out), 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // 30 - 15, item 2: vend, then 10 and 5
    accept(8'd30, 8'd15, 2'd2);
    sum_money = 8'd200;
    chk("t1_calc_busy", 32'(busy), 32'd1);
    chk("t1_calc_vv", 32'(vend_valid), 32'd0);
    step();
    chk("t1_vend_vv", 32'(vend_valid), 32'd1);
    chk("t1_vend_item", 32'(vend_item), 32'd2);
    chk("t1_rem15", 32'(remaining), 32'd15);
    step();
    chk("t1_coin_vv", 32'(vend_valid), 32'd0);
    chk("t1_coin_item", 32'(vend_item), 32'd0);
    chk("t1_coin_deno", 32'(deno), 32'd0);
    step();
    chk("t1_req10", 32'(deno), 32'b010);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    chk("t1_rem5", 32'(remaining), 32'd5);
    chk("t1_drop10", 32'(deno), 32'd0);
    step();
    chk("t1_req5", 32'(deno), 32'b001);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    chk("t1_rem0", 32'(remaining), 32'd0);
    chk("t1_cd_early", 32'(change_done), 32'd0);
    step();
    chk("t1_cd", 32'(change_done), 32'd1);
    chk("t1_err", 32'(err_code), 32'd0);
    chk("t1_resid", 32'(residual), 32'd0);
    chk("t1_fin_busy", 32'(busy), 32'd1);
    step();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_cd_drop", 32'(change_done), 32'd0);

    // 6 - 5: vend, no coins, residual 1; later input changes ignored
    accept(8'd6, 8'd5, 2'd1);
    sum_money = 8'd200; price = 8'd0;
    step();
    chk("t2_vv", 32'(vend_valid), 32'd1);
    chk("t2_item", 32'(vend_item), 32'd1);
    chk("t2_rem", 32'(remaining), 32'd1);
    step();
    chk("t2_coin_cd", 32'(change_done), 32'd0);
    chk("t2_coin_deno", 32'(deno), 32'd0);
    step();
    chk("t2_cd", 32'(change_done), 32'd1);
    chk("t2_resid", 32'(residual), 32'd1);
    chk("t2_err", 32'(err_code), 32'd2);
    chk("t2_deno", 32'(deno), 32'd0);
    step();

    // 45 refund, ack held high throughout: 20, 20, 5
    coin_ack = 1'b1;
    accept(8'd45, 8'd0, 2'd3);
    chk("t3_err_clr", 32'(err_code), 32'd0);
    chk("t3_resid_clr", 32'(residual), 32'd0);
    step();
    chk("t3_vv", 32'(vend_valid), 32'd0);
    chk("t3_rem45", 32'(remaining), 32'd45);
    chk("t3_coin_deno", 32'(deno), 32'd0);
    step();
    chk("t3_req20a", 32'(deno), 32'b100);
    step();
    chk("t3_rem25", 32'(remaining), 32'd25);
    step();
    chk("t3_req20b", 32'(deno), 32'b100);
    step();
    chk("t3_rem5", 32'(remaining), 32'd5);
    step();
    chk("t3_req5", 32'(deno), 32'b001);
    step();
    chk("t3_rem0", 32'(remaining), 32'd0);
    coin_ack = 1'b0;
    step();
    chk("t3_cd", 32'(change_done), 32'd1);
    chk("t3_err", 32'(err_code), 32'd0);
    step();

    // 10 with price 20: underpay, full refund as one 10
    accept(8'd10, 8'd20, 2'd1);
    step();
    chk("t4_vv", 32'(vend_valid), 32'd0);
    chk("t4_rem", 32'(remaining), 32'd10);
    chk("t4_err_early", 32'(err_code), 32'd1);
    step();
    chk("t4_req10", 32'(deno), 32'b010);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    chk("t4_rem0", 32'(remaining), 32'd0);
    step();
    chk("t4_cd", 32'(change_done), 32'd1);
    chk("t4_err", 32'(err_code), 32'd1);
    step();

    // 25 refund, no ack: timeout after T cycles; done while busy ignored
    accept(8'd25, 8'd0, 2'd0);
    step();
    step();
    hi = 0;
    while (deno_20 && hi < 3 * T) begin
      hi++;
      if (hi == 3) begin done = 1'b1; end_trans = 1'b1; sum_money = 8'd99; end
      if (hi == 4) begin done = 1'b0; end_trans = 1'b0; end
      step();
    end
    chk("t5_req_cycles", 32'(hi), 32'(T));
    chk("t5_cd", 32'(change_done), 32'd1);
    chk("t5_err", 32'(err_code), 32'd3);
    chk("t5_rem", 32'(remaining), 32'd25);
    chk("t5_resid", 32'(residual), 32'd0);
    chk("t5_deno", 32'(deno), 32'd0);
    step();
    chk("t5_idle", 32'(busy), 32'd0);
    step();
    chk("t5_not_queued", 32'(busy), 32'd0);

    // Ack on the exact expiry edge pays the coin
    accept(8'd25, 8'd0, 2'd0);
    step();
    step();
    chk("t6_req20", 32'(deno), 32'b100);
    for (int i = 0; i < int'(T) - 1; i++) step();
    chk("t6_still_req", 32'(deno), 32'b100);
    coin_ack = 1'b1;
    step();
    chk("t6_rem5", 32'(remaining), 32'd5);
    chk("t6_no_cd", 32'(change_done), 32'd0);
    chk("t6_err", 32'(err_code), 32'd0);
    step();
    chk("t6_req5", 32'(deno), 32'b001);
    step();
    coin_ack = 1'b0;
    step();
    chk("t6_cd", 32'(change_done), 32'd1);
    chk("t6_err_fin", 32'(err_code), 32'd0);
    step();

    // Async reset while deno_20 is asserted
    accept(8'd25, 8'd0, 2'd0);
    step();
    step();
    chk("t7_req20", 32'(deno), 32'b100);
    #2 reset_n = 1'b0;
    #1 chk("t7_async_zero", 32'(all_out), 32'd0);
    step();
    #2 reset_n = 1'b1;
    step();
    chk("t7_post_busy", 32'(busy), 32'd0);
    chk("t7_post_deno", 32'(deno), 32'd0);

    // done without end_trans is ignored
    done = 1'b1; end_trans = 1'b0; sum_money = 8'd40;
    step();
    done = 1'b0;
    chk("t8_no_accept", 32'(busy), 32'd0);
    step();
    chk("t8_rem", 32'(remaining), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Back end of the vending controller's completion interface. It accepts the `done`/`end_trans` strobe with `sum_money`, `price` and `item_select`, then issues a one-cycle item-vend pulse. It then pays out change (`sum_money - price`) greedily as 20/10/5 coins over a request/acknowledge handshake with the coin mechanism, and reports completion, leftover residue and error status.

## Interface
Parameters:
- `ACK_TIMEOUT`, 16: cycles a coin request may wait for `coin_ack` before the payout aborts; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `done`  in  1  transaction-complete strobe from the controller.
- `end_trans`  in  1  qualifies `done`; a transaction is accepted only when both are high.
- `sum_money`  in  8  total money inserted (unsigned, money units).
- `price`  in  8  price of the selected item; 0 means refund only, with no vend.
- `item_select`  in  2  item index to vend.
- `coin_ack`  in  1  coin mechanism has taken the currently requested coin.
- `deno_20`, `deno_10`, `deno_5`  out  1 each  one-hot coin request, held until acknowledged.
- `vend_valid`  out  1  one-cycle item release pulse.
- `vend_item`  out  2  item index; valid while `vend_valid` is high, otherwise 0.
- `busy`  out  1  a transaction is in progress.
- `change_done`  out  1  one-cycle pulse at the end of a transaction.
- `remaining`  out  8  change still owed.
- `residual`  out  3  leftover below 5 that cannot be paid; valid from `change_done` until the next accept.
- `err_code`  out  2  0 none, 1 underpay (`price > sum_money`), 2 residual ≠ 0, 3 ack timeout; held until the next accept.

## Operation
- FSM states: IDLE, CALC, VEND, COIN, WAIT_ACK, FINISH. All outputs are registered or decoded from the state (Moore).
- IDLE:
  - `busy`=0.
  - On a rising edge with `done && end_trans`, capture `sum_money`, `price`, `item_select`; clear `err_code` and `residual`; go to CALC.
- CALC (1 cycle):
  - `price==0`: `remaining`=sum, no vend.
  - `price>sum`: `remaining`=sum (full refund), no vend, `err_code`=1.
  - Otherwise: `remaining`=sum−price, vend.
  - Next state is VEND if vending, else COIN.
- VEND (1 cycle): `vend_valid`=1, `vend_item`=captured item. Next state COIN.
- COIN (1 cycle, decision):
  - `remaining`≥20 selects 20; else ≥10 selects 10; else ≥5 selects 5, then go to WAIT_ACK.
  - `remaining`<5: go to FINISH.
- WAIT_ACK:
  - The selected `deno_*` is high; exactly one is high at any time.
  - `coin_ack` sampled high: `remaining` -= coin value, request drops, return to COIN.
  - Timeout counter reaches `ACK_TIMEOUT` with no ack: `err_code`=3, go to FINISH with `remaining` unchanged.
- FINISH (1 cycle):
  - `change_done`=1; `residual`=`remaining[2:0]` (only if no timeout).
  - If `err_code` is still 0 and residual≠0, set `err_code`=2.
  - Return to IDLE.
- Arithmetic: 8-bit unsigned. Subtraction never underflows, because a coin is selected only if its value ≤ `remaining`.
- `busy`=1 in every state except IDLE.

## Timing
- Reset (async, any state): state IDLE; all outputs 0, including `remaining`, `residual`, `err_code`; timeout counter 0; captured data discarded. An in-flight coin request drops immediately.
- Accept at edge N:
  - CALC during cycle N+1.
  - `vend_valid` high during cycle N+2 (if vending).
  - First coin request high starting at edge N+3 with vend, or N+2 without.
- Each coin costs a minimum of 2 cycles (COIN + WAIT_ACK), with `coin_ack` high in the first WAIT_ACK cycle.
- `change_done` occurs one cycle after the COIN decision with `remaining`<5. The cycle after `change_done`, `busy`=0 and a new accept is possible.
- Boundary conditions:
  - `done` while `busy`: ignored, not queued.
  - `coin_ack` outside WAIT_ACK: ignored.
  - `coin_ack` on the same edge as the timeout expiry: the ack wins.
  - `done` without `end_trans`: ignored.
  - Inputs are sampled only at the accept edge; later changes have no effect.

## Test plan
- `sum_money`=30, `price`=15, `item_select`=2, `coin_ack` returned 1 cycle after each request → `vend_valid` pulse with `vend_item`=2, then `deno_10` followed by `deno_5`, `remaining` 15→5→0, `change_done` pulse, `err_code`=0, `residual`=0.
- `sum_money`=6, `price`=5 → vend, no coin requests, `residual`=1, `err_code`=2, `change_done` 4 cycles after accept.
- `sum_money`=45, `price`=0 (refund) → no `vend_valid`; coins 20, 20, 5; `err_code`=0.
- `sum_money`=10, `price`=20 → no vend, `deno_10` once, `err_code`=1.
- `sum_money`=25, `price`=0, `coin_ack` held low → `deno_20` high for exactly `ACK_TIMEOUT` cycles, then `change_done`, `err_code`=3, `remaining`=25.
- `reset_n` pulsed low while `deno_20` is asserted → all outputs 0 asynchronously; a second `done` during `busy` is shown to be ignored.
